// File: rtl/uart_rx_async.sv
// UART receiver: 16x oversampled, 7/8 data bits, optional parity, holding register or external FIFO.
// Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 voting on samples 6/7/8 (decision one tick later).
module uart_rx_async #(
    parameter bit SYNC_RESET = 1'b0,
    parameter bit RX_FIFO    = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       baud_clock,
    input  logic       rx,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic       read_rx_byte,
    input  logic       clear_parity,
    input  logic       clear_framing,
    input  logic       fifo_empty,
    output logic [7:0] rx_dout,
    output logic       rx_ready,
    output logic       parity_err,
    output logic       framing_err,
    output logic       overflow,
    output logic       fifo_write,
    output logic       rx_idle
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t     state;
    logic       rx_meta, rx_s;
    logic [3:0] samp_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic [7:0] pend_byte;
    logic       acc;
    logic       wait_high;
    logic       deliver;
    logic       bit_val;
    logic       centre;

    // Async reset is tied off when the synchronous flavour is selected, and vice versa.
    logic arst_n, srst;
    assign arst_n = SYNC_RESET ? 1'b1 : reset_n;
    assign srst   = SYNC_RESET ? !reset_n : 1'b0;

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [3:0] DEC_CNT = 4'd8;
    logic s6, s7;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            s6 <= 1'b1;
            s7 <= 1'b1;
        end else if (srst) begin
            s6 <= 1'b1;
            s7 <= 1'b1;
        end else if (baud_clock) begin
            if (samp_cnt == 4'd6) s6 <= rx_s;
            if (samp_cnt == 4'd7) s7 <= rx_s;
        end
    end

    assign bit_val = (s6 & s7) | (s6 & rx_s) | (s7 & rx_s);
`else
    localparam logic [3:0] DEC_CNT = 4'd7;
    assign bit_val = rx_s;
`endif

    assign centre  = baud_clock && (samp_cnt == DEC_CNT);
    assign rx_idle = (state == IDLE);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else if (srst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            // NOTE: non-blocking so rx_s sees the previous rx_meta, giving a true two-flop chain.
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= IDLE;
            samp_cnt    <= 4'd0;
            bit_cnt     <= 3'd0;
            shift_reg   <= 8'd0;
            pend_byte   <= 8'd0;
            acc         <= 1'b0;
            wait_high   <= 1'b0;
            deliver     <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
        end else if (srst) begin
            state       <= IDLE;
            samp_cnt    <= 4'd0;
            bit_cnt     <= 3'd0;
            shift_reg   <= 8'd0;
            pend_byte   <= 8'd0;
            acc         <= 1'b0;
            wait_high   <= 1'b0;
            deliver     <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            deliver <= 1'b0;
            if (baud_clock) samp_cnt <= samp_cnt + 4'd1;
            if (clear_parity)  parity_err  <= 1'b0;
            if (clear_framing) framing_err <= 1'b0;

            // Error sets below come after the clears so a coincident new error wins.
            case (state)
                IDLE: begin
                    if (wait_high) begin
                        if (rx_s) wait_high <= 1'b0;
                    end else if (baud_clock && !rx_s) begin
                        state    <= START;
                        samp_cnt <= 4'd0;
                    end
                end
                START: begin
                    if (centre) begin
                        if (!bit_val) begin
                            state   <= DATA;
                            bit_cnt <= 3'd0;
                            acc     <= odd_n_even;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (centre) begin
                        shift_reg <= {bit_val, shift_reg[7:1]};
                        acc       <= acc ^ bit_val;
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == (bit8 ? 3'd7 : 3'd6))
                            state <= parity_en ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (centre) begin
                        if (bit_val ^ acc) parity_err <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (centre) begin
                        if (!bit_val) begin
                            framing_err <= 1'b1;
                            wait_high   <= 1'b1;
                        end
                        // Seven-bit frames leave the data in [7:1] after seven shifts.
                        pend_byte <= bit8 ? shift_reg : {1'b0, shift_reg[7:1]};
                        deliver   <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rx_dout    <= 8'd0;
            rx_ready   <= 1'b0;
            overflow   <= 1'b0;
            fifo_write <= 1'b0;
        end else if (srst) begin
            rx_dout    <= 8'd0;
            rx_ready   <= 1'b0;
            overflow   <= 1'b0;
            fifo_write <= 1'b0;
        end else if (RX_FIFO) begin
            fifo_write <= deliver;
            rx_ready   <= !fifo_empty;
            overflow   <= 1'b0;
            if (deliver) rx_dout <= pend_byte;
        end else begin
            fifo_write <= 1'b0;
            if (read_rx_byte) overflow <= 1'b0;
            if (deliver) begin
                if (rx_ready && !read_rx_byte) begin
                    overflow <= 1'b1;
                end else begin
                    rx_dout  <= pend_byte;
                    rx_ready <= 1'b1;
                end
            end else if (read_rx_byte) begin
                rx_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_async.sv
// Self-checking bench for uart_rx_async: holding-register instance plus an RX_FIFO instance on the same line.
module tb_uart_rx_async;

    localparam int BIT_CLKS = 64;  // 16 ticks x 4 clk per tick

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic baud_clock = 1'b0;
    logic [1:0] baud_div = 2'd0;
    logic rx = 1'b1;
    logic bit8 = 1'b1, parity_en = 1'b0, odd_n_even = 1'b0;
    logic read_rx_byte = 1'b0, clear_parity = 1'b0, clear_framing = 1'b0;
    logic fifo_empty = 1'b1;

    logic [7:0] dout0, dout1;
    logic ready0, perr0, ferr0, ovf0, fw0, idle0;
    logic ready1, perr1, ferr1, ovf1, fw1, idle1;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] seen_q[$];
    bit tx_done;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        baud_div   <= baud_div + 2'd1;
        baud_clock <= (baud_div == 2'd3);
    end

    uart_rx_async #(.SYNC_RESET(1'b0), .RX_FIFO(1'b0)) dut (
        .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock), .rx(rx),
        .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
        .read_rx_byte(read_rx_byte), .clear_parity(clear_parity),
        .clear_framing(clear_framing), .fifo_empty(fifo_empty),
        .rx_dout(dout0), .rx_ready(ready0), .parity_err(perr0),
        .framing_err(ferr0), .overflow(ovf0), .fifo_write(fw0), .rx_idle(idle0)
    );

    uart_rx_async #(.SYNC_RESET(1'b0), .RX_FIFO(1'b1)) dut_fifo (
        .clk(clk), .reset_n(reset_n), .baud_clock(baud_clock), .rx(rx),
        .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
        .read_rx_byte(read_rx_byte), .clear_parity(clear_parity),
        .clear_framing(clear_framing), .fifo_empty(fifo_empty),
        .rx_dout(dout1), .rx_ready(ready1), .parity_err(perr1),
        .framing_err(ferr1), .overflow(ovf1), .fifo_write(fw1), .rx_idle(idle1)
    );

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input int nbits,
                              input bit with_par, input logic par_val, input logic stop_val);
        drive_bit(1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(data[i]);
        if (with_par) drive_bit(par_val);
        drive_bit(stop_val);
    endtask

    task automatic pulse(input int which);
        case (which)
            0: read_rx_byte = 1'b1;
            1: clear_parity = 1'b1;
            default: clear_framing = 1'b1;
        endcase
        @(posedge clk);
        #1;
        read_rx_byte = 1'b0;
        clear_parity = 1'b0;
        clear_framing = 1'b0;
    endtask

    function automatic logic [7:0] pop_exp();
        if (exp_q.size() == 0) return 8'hxx;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (dout0 !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", dout0); end
        checks++; if ({ready0, perr0, ferr0, ovf0, fw0} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {ready0, perr0, ferr0, ovf0, fw0}); end
        checks++; if (idle0 !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", idle0); end
        checks++; if ({ready1, fw1, ovf1} !== 3'b0) begin errors++; $display("FAIL reset_fifo_flags: got %b expected 000", {ready1, fw1, ovf1}); end
    endtask

    task automatic test_8n1();
        logic [7:0] exp;
        bit8 = 1'b1; parity_en = 1'b0;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
        exp = pop_exp();
        checks++; if (dout0 !== exp) begin errors++; $display("FAIL 8n1_data: got %h expected %h", dout0, exp); end
        checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL 8n1_ready: got %b expected 1", ready0); end
        checks++; if ({perr0, ferr0, ovf0} !== 3'b0) begin errors++; $display("FAIL 8n1_errors: got %b expected 000", {perr0, ferr0, ovf0}); end
        pulse(0);
        checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL 8n1_read_clears: got %b expected 0", ready0); end
    endtask

    task automatic test_parity();
        logic [7:0] exp;
        bit8 = 1'b0; parity_en = 1'b1; odd_n_even = 1'b0;
        // 0x35 has four ones in its low seven bits: even parity bit is 0, so 1 is wrong.
        exp_q.push_back(8'h35);
        send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1);
        exp = pop_exp();
        checks++; if (dout0 !== exp) begin errors++; $display("FAIL 7e1_data: got %h expected %h", dout0, exp); end
        checks++; if (perr0 !== 1'b1) begin errors++; $display("FAIL 7e1_bad_parity: got %b expected 1", perr0); end
        checks++; if (ferr0 !== 1'b0) begin errors++; $display("FAIL 7e1_framing: got %b expected 0", ferr0); end
        pulse(1);
        checks++; if (perr0 !== 1'b0) begin errors++; $display("FAIL 7e1_clear_parity: got %b expected 0", perr0); end
        pulse(0);
        exp_q.push_back(8'h35);
        send_frame(8'h35, 7, 1'b1, 1'b0, 1'b1);
        exp = pop_exp();
        checks++; if (dout0 !== exp) begin errors++; $display("FAIL 7e1_good_data: got %h expected %h", dout0, exp); end
        checks++; if (perr0 !== 1'b0) begin errors++; $display("FAIL 7e1_good_parity: got %b expected 0", perr0); end
        pulse(0);
        bit8 = 1'b1; parity_en = 1'b0;
    endtask

    task automatic test_framing();
        logic [7:0] exp;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0);
        repeat (160) @(posedge clk);
        #1;
        exp = pop_exp();
        checks++; if (ferr0 !== 1'b1) begin errors++; $display("FAIL framing_flag: got %b expected 1", ferr0); end
        checks++; if (dout0 !== exp) begin errors++; $display("FAIL framing_data: got %h expected %h", dout0, exp); end
        checks++; if (idle0 !== 1'b1) begin errors++; $display("FAIL framing_break_idle: got %b expected 1", idle0); end
        rx = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        pulse(2);
        pulse(0);
        checks++; if ({ferr0, ready0} !== 2'b00) begin errors++; $display("FAIL framing_clear: got %b expected 00", {ferr0, ready0}); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
        exp = pop_exp();
        checks++; if (dout0 !== exp) begin errors++; $display("FAIL overflow_keeps_old: got %h expected %h", dout0, exp); end
        checks++; if ({ovf0, ready0} !== 2'b11) begin errors++; $display("FAIL overflow_flag: got %b expected 11", {ovf0, ready0}); end
        pulse(0);
        checks++; if ({ovf0, ready0} !== 2'b00) begin errors++; $display("FAIL overflow_read_clears: got %b expected 00", {ovf0, ready0}); end
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        repeat (20) @(posedge clk);
        #1 rx = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        checks++; if ({idle0, ready0, ferr0, perr0} !== 4'b1000) begin errors++; $display("FAIL glitch_reject: got %b expected 1000", {idle0, ready0, ferr0, perr0}); end
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'h77, 8, 1'b0, 1'b0, 1'b1);
        rx = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        checks++; if (idle0 !== 1'b0) begin errors++; $display("FAIL midframe_busy: got %b expected 0", idle0); end
        reset_n = 1'b0;
        #3;
        checks++; if ({dout0, ready0, ovf0, idle0} !== {8'h00, 3'b001}) begin errors++; $display("FAIL midframe_reset: got %h expected 001", {dout0, ready0, ovf0, idle0}); end
        rx = 1'b1;
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_fifo();
        int writes = 0;
        logic [7:0] exp;
        fifo_empty = 1'b1;
        tx_done = 1'b0;
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'hC3);
        fork
            begin
                send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
                send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1);
                tx_done = 1'b1;
            end
            begin
                while (!tx_done) begin
                    @(negedge clk);
                    if (fw1) begin
                        writes++;
                        seen_q.push_back(dout1);
                    end
                end
            end
        join
        checks++; if (writes !== 2) begin errors++; $display("FAIL fifo_write_count: got %0d expected 2", writes); end
        for (int i = 0; i < 2; i++) begin
            exp = pop_exp();
            checks++;
            if (seen_q.size() == 0) begin
                errors++; $display("FAIL fifo_data_missing: got none expected %h", exp);
            end else if (seen_q[0] !== exp) begin
                errors++; $display("FAIL fifo_data: got %h expected %h", seen_q[0], exp);
                void'(seen_q.pop_front());
            end else begin
                void'(seen_q.pop_front());
            end
        end
        checks++; if ({ovf1, ready1} !== 2'b00) begin errors++; $display("FAIL fifo_no_overflow: got %b expected 00", {ovf1, ready1}); end
        fifo_empty = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL fifo_ready_tracks: got %b expected 1", ready1); end
        fifo_empty = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ready1 !== 1'b0) begin errors++; $display("FAIL fifo_ready_empty: got %b expected 0", ready1); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_framing();
        test_back_to_back();
        test_glitch();
        test_reset_mid_frame();
        test_fifo();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
